// File: rtl/interleave_out_framer.sv
// Frames de-interleaved DDR4 read-FIFO words into SOF/EOF-tagged blocks through a
// show-ahead skid buffer; the FIFO cannot be stalled, so words that find the buffer full are dropped.
module interleave_out_framer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MATRIX_COL = 8,
    parameter int unsigned MATRIX_ROW = 8,
    parameter int unsigned BUF_DEPTH  = 16
) (
    input  logic                       rd_fifo_rclk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      rd_fifo_rdata,
    input  logic                       rd_fifo_rvalid,
    output logic [DATA_WIDTH-1:0]      m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tuser,
    output logic                       m_tlast,
    output logic                       blk_busy,
    output logic [15:0]                blk_cnt,
    output logic                       ovf_err,
    output logic [$clog2(BUF_DEPTH):0] buf_level
);

    localparam int unsigned BLOCK_LEN = MATRIX_COL * MATRIX_ROW * 8;
    localparam int unsigned AW        = $clog2(BUF_DEPTH);
    localparam int unsigned PW        = AW + 1;
    localparam int unsigned IDX_W     = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int unsigned ENT_W     = DATA_WIDTH + 2;

    typedef enum logic {
        ST_IDLE,
        ST_BLOCK
    } state_e;

    // Entry layout: {sof, last, data}
    logic [ENT_W-1:0] mem_q [BUF_DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    level_q, level_d;
    logic [IDX_W-1:0] in_idx_q, in_idx_d;
    logic [15:0]      blk_cnt_q, blk_cnt_d;
    logic             ovf_q, ovf_d;
    state_e           state_q, state_d;

    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;
    logic             drop_c;
    logic             in_sof_c;
    logic             in_last_c;
    logic [ENT_W-1:0] head_c;

    assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_c   = (wr_ptr_q == rd_ptr_q);
    assign pop_c     = !empty_c && m_tready;
    assign push_c    = rd_fifo_rvalid && (!full_c || pop_c);
    assign drop_c    = rd_fifo_rvalid && full_c && !pop_c;
    assign in_sof_c  = (in_idx_q == '0);
    assign in_last_c = (in_idx_q == IDX_W'(BLOCK_LEN - 1));
    assign head_c    = mem_q[rd_ptr_q[AW-1:0]];

    // Show-ahead head; tags are gated so an empty buffer never presents SOF/EOF
    assign m_tvalid  = !empty_c;
    assign m_tdata   = head_c[DATA_WIDTH-1:0];
    assign m_tuser   = !empty_c && head_c[ENT_W-1];
    assign m_tlast   = !empty_c && head_c[ENT_W-2];
    assign blk_busy  = (state_q == ST_BLOCK);
    assign blk_cnt   = blk_cnt_q;
    assign ovf_err   = ovf_q;
    assign buf_level = level_q;

    // Storage carries no reset; validity is tracked by the pointers alone
    always_ff @(posedge rd_fifo_rclk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_sof_c, in_last_c, rd_fifo_rdata};
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        in_idx_d  = in_idx_q;
        ovf_d     = ovf_q;
        blk_cnt_d = blk_cnt_q;
        state_d   = state_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + PW'(1);
            2'b01:   level_d = level_q - PW'(1);
            default: level_d = level_q;
        endcase

        // Index advances on every offered word so drops keep later tags aligned
        if (rd_fifo_rvalid) begin
            in_idx_d = in_last_c ? '0 : in_idx_q + IDX_W'(1);
        end
        if (drop_c) begin
            ovf_d = 1'b1;
        end

        if (pop_c) begin
            if (m_tlast) begin
                blk_cnt_d = blk_cnt_q + 16'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (m_tuser && !m_tlast) begin
                        state_d = ST_BLOCK;
                    end
                end
                ST_BLOCK: begin
                    if (m_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rd_fifo_rclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            in_idx_q  <= '0;
            ovf_q     <= 1'b0;
            blk_cnt_q <= '0;
            state_q   <= ST_IDLE;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            in_idx_q  <= in_idx_d;
            ovf_q     <= ovf_d;
            blk_cnt_q <= blk_cnt_d;
            state_q   <= state_d;
        end
    end

endmodule
